// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU, load unit, debug host).
// Define REGFILE_ARB_DBG_PRIORITY_EN to give the debug port absolute priority over the other two.
module regfile_write_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_gnt,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_gnt,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        conflict_cnt,
    output logic [1:0]        last_winner
);

    logic [1:0] ptr;
    logic       seen_grant;
    logic [2:0] rr_req;
    logic [2:0] gnt;
    logic [1:0] cand;
    logic       found;
    logic       grant_any;
    logic       ptr_update;
    logic       multi_req;
    logic [1:0] win_idx;

    // With debug priority enabled, debug is taken out of the rotation so ALU and load share it.
`ifdef REGFILE_ARB_DBG_PRIORITY_EN
    assign rr_req = {1'b0, ld_req, alu_req};
`else
    assign rr_req = {dbg_req, ld_req, alu_req};
`endif

    always_comb begin
        gnt   = 3'b000;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!found && rr_req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
            end
        end
`ifdef REGFILE_ARB_DBG_PRIORITY_EN
        if (dbg_req) begin
            gnt = 3'b100;
        end
`endif
        if (rst) begin
            gnt = 3'b000;
        end
    end

    assign alu_gnt   = gnt[0];
    assign ld_gnt    = gnt[1];
    assign dbg_gnt   = gnt[2];
    assign grant_any = |gnt;

`ifdef REGFILE_ARB_DBG_PRIORITY_EN
    assign ptr_update = gnt[0] | gnt[1];
`else
    assign ptr_update = grant_any;
`endif

    assign win_idx   = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
    assign multi_req = (alu_req & ld_req) | (alu_req & dbg_req) | (ld_req & dbg_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= 2'd2;
            seen_grant   <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            conflict_cnt <= 8'd0;
        end else begin
            wr_en <= grant_any;
            if (grant_any) begin
                seen_grant <= 1'b1;
                case (win_idx)
                    2'd1:    begin wr_addr <= ld_addr;  wr_data <= ld_data;  end
                    2'd2:    begin wr_addr <= dbg_addr; wr_data <= dbg_data; end
                    default: begin wr_addr <= alu_addr; wr_data <= alu_data; end
                endcase
            end
            if (ptr_update) begin
                ptr <= win_idx;
            end
            if (multi_req && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

    assign last_winner = seen_grant ? ptr : 2'd3;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, contention order, saturation, reset mid-stream.
// Expectations follow REGFILE_ARB_DBG_PRIORITY_EN when the bench is built with it.
module tb_regfile_write_arbiter;

    logic       clk;
    logic       rst;
    logic       alu_req, ld_req, dbg_req;
    logic [1:0] alu_addr, ld_addr, dbg_addr;
    logic [7:0] alu_data, ld_data, dbg_data;
    logic       alu_gnt, ld_gnt, dbg_gnt;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] conflict_cnt;
    logic [1:0] last_winner;

    int vectors;
    int miscompares;

    regfile_write_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .conflict_cnt(conflict_cnt), .last_winner(last_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant is a requester index, or 3 for no grant at all.
    task automatic check_gnt(input string tag, input int idx);
        logic [2:0] exp;
        exp = (idx == 3) ? 3'b000 : (3'b001 << idx);
        check(tag, {29'd0, dbg_gnt, ld_gnt, alu_gnt}, {29'd0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int         order3[6];
    int         pair3[3];
    logic [1:0] addr_tab[3];
    logic [7:0] data_tab[3];
    int         exp_lw3;

    initial begin
        vectors     = 0;
        miscompares = 0;
        addr_tab = '{2'd0, 2'd1, 2'd3};
        data_tab = '{8'h11, 8'h22, 8'h33};
`ifdef REGFILE_ARB_DBG_PRIORITY_EN
        order3  = '{2, 2, 2, 2, 2, 2};
        pair3   = '{2, 2, 2};
        exp_lw3 = 2;
`else
        order3  = '{0, 1, 2, 0, 1, 2};
        pair3   = '{0, 2, 0};
        exp_lw3 = 2;
`endif
        rst = 1'b1;
        alu_req = 0; ld_req = 0; dbg_req = 0;
        alu_addr = 0; ld_addr = 0; dbg_addr = 0;
        alu_data = 0; ld_data = 0; dbg_data = 0;

        // Reset held two edges; a request during reset must not be granted.
        @(posedge clk);
        next_cycle();
        alu_req = 1; alu_addr = 2'd1; alu_data = 8'h77;
        @(negedge clk);
        check_gnt("gnt_during_reset", 3);
        check("reset_wr_en", wr_en, 0);
        check("reset_cnt", conflict_cnt, 0);
        check("reset_last_winner", last_winner, 3);
        next_cycle();
        rst = 0; alu_req = 0;

        repeat (5) begin
            @(negedge clk);
            check_gnt("idle_gnt", 3);
            next_cycle();
        end
        @(negedge clk);
        check("idle_wr_en", wr_en, 0);
        check("idle_cnt", conflict_cnt, 0);
        check("idle_last_winner", last_winner, 3);
        next_cycle();

        // Single ALU write.
        alu_req = 1; alu_addr = 2'd2; alu_data = 8'hA5;
        @(negedge clk);
        check_gnt("single_alu_gnt", 0);
        next_cycle();
        alu_req = 0;
        @(negedge clk);
        check("single_wr_en", wr_en, 1);
        check("single_wr_addr", wr_addr, 2);
        check("single_wr_data", wr_data, 8'hA5);
        check("single_last_winner", last_winner, 0);
        next_cycle();
        @(negedge clk);
        check("single_wr_en_off", wr_en, 0);
        check("single_addr_hold", wr_addr, 2);
        check("single_data_hold", wr_data, 8'hA5);
        next_cycle();

        // Fresh reset so the pointer is back at 2 before the contention run.
        rst = 1;
        next_cycle();
        rst = 0;
        alu_req = 1; alu_addr = addr_tab[0]; alu_data = data_tab[0];
        ld_req  = 1; ld_addr  = addr_tab[1]; ld_data  = data_tab[1];
        dbg_req = 1; dbg_addr = addr_tab[2]; dbg_data = data_tab[2];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_gnt($sformatf("three_way_gnt%0d", i), order3[i]);
            check($sformatf("three_way_cnt%0d", i), conflict_cnt, i);
            if (i > 0) begin
                check($sformatf("three_way_wr_en%0d", i), wr_en, 1);
                check($sformatf("three_way_addr%0d", i), wr_addr, addr_tab[order3[i-1]]);
                check($sformatf("three_way_data%0d", i), wr_data, data_tab[order3[i-1]]);
            end
            next_cycle();
        end
        alu_req = 0; ld_req = 0; dbg_req = 0;
        @(negedge clk);
        check("three_way_last_wr_en", wr_en, 1);
        check("three_way_last_data", wr_data, data_tab[order3[5]]);
        check("three_way_cnt", conflict_cnt, 6);
        check("three_way_last_winner", last_winner, exp_lw3);
        next_cycle();

        // Debug and ALU together: alternate, or debug always under priority mode.
        alu_req = 1; dbg_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_gnt($sformatf("dbg_alu_gnt%0d", i), pair3[i]);
            next_cycle();
        end
        alu_req = 0; dbg_req = 0;
        @(negedge clk);
        check("dbg_alu_cnt", conflict_cnt, 9);
        next_cycle();

        // Load granted, then reset lands on the following edge.
        ld_req = 1; ld_addr = 2'd1; ld_data = 8'h5C;
        @(negedge clk);
        check_gnt("mid_ld_gnt", 1);
        next_cycle();
        rst = 1; ld_req = 0;
        @(negedge clk);
        check("mid_wr_en_pre", wr_en, 1);
        check("mid_wr_addr_pre", wr_addr, 1);
        check("mid_wr_data_pre", wr_data, 8'h5C);
        next_cycle();
        rst = 0; ld_req = 1; ld_data = 8'h5D;
        @(negedge clk);
        check("mid_wr_en_post", wr_en, 0);
        check("mid_wr_addr_post", wr_addr, 0);
        check("mid_wr_data_post", wr_data, 0);
        check("mid_cnt_post", conflict_cnt, 0);
        check("mid_last_winner_post", last_winner, 3);
        check_gnt("mid_reld_gnt", 1);
        next_cycle();
        ld_req = 0;
        @(negedge clk);
        check("mid_reld_wr_en", wr_en, 1);
        check("mid_reld_data", wr_data, 8'h5D);
        check("mid_reld_last_winner", last_winner, 1);
        next_cycle();

        // Saturation: ALU and load contend for 300 cycles, pointer starts at 1 so ALU goes first.
        alu_req = 1; alu_addr = 2'd0; alu_data = 8'hC0;
        ld_req  = 1; ld_addr  = 2'd1; ld_data  = 8'hC1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check_gnt("sat_alternate", (i % 2 == 0) ? 0 : 1);
            if (i == 254) begin
                check("sat_cnt_254", conflict_cnt, 8'hFE);
            end
            next_cycle();
        end
        alu_req = 0; ld_req = 0;
        @(negedge clk);
        check("sat_cnt_ff", conflict_cnt, 8'hFF);
        next_cycle();
        alu_req = 1; ld_req = 1;
        next_cycle();
        alu_req = 0; ld_req = 0;
        @(negedge clk);
        check("sat_no_wrap", conflict_cnt, 8'hFF);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
